// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - SOF/LEN/payload/CSUM framer; payload released only after checksum passes
module uart_frame_rx #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF            = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = (CLK_HZ / 115200) * 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic [7:0] o_out_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);

  localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [7:0]       r_sum;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       r_buf [0:(1 << BUF_AW) - 1];

  logic [7:0]       w_csum;
  logic             w_timeout;
  logic             w_len_bad;
  logic             w_xfer;
  logic [IDX_W-1:0] w_last_idx;
  logic [IDX_W-1:0] w_rd_next;

  assign w_csum     = r_sum + i_in_data;
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYCLES));
  assign w_len_bad  = (i_in_data == 8'd0) || (i_in_data > 8'(MAX_LEN));
  assign w_xfer     = o_out_valid && i_out_ready;
  assign w_last_idx = r_len - IDX_W'(1);
  assign w_rd_next  = r_rd_idx + IDX_W'(1);

  // Payload storage has no reset; only bytes below r_len are ever read back.
  always_ff @(posedge i_clk) begin
    if (r_state == S_PAYLOAD && i_in_valid && !w_timeout) begin
      r_buf[r_idx[BUF_AW-1:0]] <= i_in_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_HUNT;
      r_len       <= '0;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_sum       <= 8'h00;
      r_timer     <= '0;
      o_out_data  <= 8'h00;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= 2'b00;
    end else begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= 2'b00;
      case (r_state)
        S_HUNT: begin
          r_sum   <= 8'h00;
          r_timer <= '0;
          if (i_in_valid && i_in_data == SOF) begin
            r_state <= S_LEN;
          end
        end
        S_LEN, S_PAYLOAD, S_CSUM: begin
          // Timeout wins over a byte landing on the same cycle; that byte is dropped.
          if (w_timeout) begin
            o_frame_err <= 1'b1;
            o_err_code  <= 2'd2;
            r_timer     <= '0;
            r_state     <= S_HUNT;
          end else begin
            r_timer <= i_in_valid ? '0 : r_timer + TMR_W'(1);
            if (i_in_valid) begin
              case (r_state)
                S_LEN: begin
                  if (w_len_bad) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= 2'd0;
                    r_state     <= S_HUNT;
                  end else begin
                    r_len   <= i_in_data[IDX_W-1:0];
                    r_sum   <= i_in_data;
                    r_idx   <= '0;
                    r_state <= S_PAYLOAD;
                  end
                end
                S_PAYLOAD: begin
                  r_sum <= w_csum;
                  r_idx <= r_idx + IDX_W'(1);
                  if (r_idx == w_last_idx) begin
                    r_state <= S_CSUM;
                  end
                end
                default: begin
                  if (w_csum == 8'h00) begin
                    o_frame_ok  <= 1'b1;
                    r_rd_idx    <= '0;
                    o_out_valid <= 1'b1;
                    o_out_data  <= r_buf[0];
                    o_out_last  <= (r_len == IDX_W'(1));
                    r_state     <= S_DRAIN;
                  end else begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= 2'd1;
                    r_state     <= S_HUNT;
                  end
                end
              endcase
            end
          end
        end
        S_DRAIN: begin
          if (i_in_valid) begin
            o_frame_err <= 1'b1;
            o_err_code  <= 2'd3;
          end
          if (w_xfer) begin
            if (o_out_last) begin
              o_out_valid <= 1'b0;
              o_out_last  <= 1'b0;
              o_out_data  <= 8'h00;
              r_state     <= S_HUNT;
            end else begin
              r_rd_idx   <= w_rd_next;
              o_out_data <= r_buf[w_rd_next[BUF_AW-1:0]];
              o_out_last <= (w_rd_next == w_last_idx);
            end
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - bench for uart_frame_rx: directed frames plus randomized streams vs a frame parser model
module tb_uart_frame_rx;
  localparam int MAX_LEN = 16;
  localparam int TOUT    = 43400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_ok, frame_err;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail = 0;
  int viol = 0;
  int cyc = 0;
  int last_edge = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_cyc[$];
  int         ok_cyc_q[$];
  int         err_code_q[$];
  int         err_cyc_q[$];
  logic       prev_stall = 1'b0;
  logic       prev_rstn = 1'b0;
  logic       prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .SOF(8'hA5), .TIMEOUT_CYCLES(TOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_last(out_last), .o_frame_ok(frame_ok), .o_frame_err(frame_err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records transfers and pulses; flags stall instability and illegal pulse combinations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      if (frame_ok) ok_cyc_q.push_back(cyc);
      if (frame_err) begin
        err_code_q.push_back(int'(err_code));
        err_cyc_q.push_back(cyc);
      end
      if ((frame_ok && frame_err) || (!frame_err && err_code != 2'b00) ||
          (prev_rstn && prev_stall && !(out_valid && out_data == prev_data && out_last == prev_last)))
        viol <= viol + 1;
    end
    prev_stall <= rst_n && out_valid && !out_ready;
    prev_data  <= out_data;
    prev_last  <= out_last;
    prev_rstn  <= rst_n;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    last_edge = cyc;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input int gap);
    foreach (bs[k]) begin
      drive_byte(bs[k]);
      idle(gap);
    end
  endtask

  task automatic clear_q();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    ok_cyc_q.delete(); err_code_q.delete(); err_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %0h exp 00", out_data); end
    n_tests++; if ({out_last, frame_ok, frame_err, err_code} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %0b exp 0", {out_last, frame_ok, frame_err, err_code}); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    logic [7:0] f[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    logic [7:0] p[$] = '{8'h11, 8'h22, 8'h33};
    int ce;
    clear_q();
    out_ready = 1'b1;
    send_bytes(f, 434);
    ce = last_edge;
    n_tests++; if (ok_cyc_q.size() != 1 || err_code_q.size() != 0) begin
      n_fail++; $display("FAIL good_pulses got ok=%0d err=%0d exp ok=1 err=0", ok_cyc_q.size(), err_code_q.size()); end
    n_tests++; if (ok_cyc_q.size() > 0 && ok_cyc_q[0] != ce) begin
      n_fail++; $display("FAIL good_ok_cycle got %0d exp %0d", ok_cyc_q[0], ce); end
    n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL good_count got %0d exp 3", got_data.size()); end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      n_tests++; if (got_data[k] !== p[k] || got_last[k] !== (k == 2) || got_cyc[k] != ce + k) begin
        n_fail++; $display("FAIL good_byte%0d got %0h/last%0b/cyc%0d exp %0h/last%0b/cyc%0d",
                          k, got_data[k], got_last[k], got_cyc[k], p[k], (k == 2), ce + k); end
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_idle got valid %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] f[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    logic [7:0] p[$] = '{8'h11, 8'h22, 8'h33};
    int v0;
    clear_q();
    v0 = viol;
    out_ready = 1'b0;
    send_bytes(f, 2);
    for (int t = 0; t < 20; t++) begin
      idle(3);
      out_ready = !out_ready;
    end
    out_ready = 1'b1;
    idle(5);
    n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", got_data.size()); end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      n_tests++; if (got_data[k] !== p[k] || got_last[k] !== (k == 2)) begin
        n_fail++; $display("FAIL bp_byte%0d got %0h/%0b exp %0h/%0b", k, got_data[k], got_last[k], p[k], (k == 2)); end
    end
    n_tests++; if (viol != v0) begin n_fail++; $display("FAIL bp_stable got %0d violations exp 0", viol - v0); end
  endtask

  task automatic test_bad_csum();
    logic [7:0] bad[$]  = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h5A};
    logic [7:0] good[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    clear_q();
    out_ready = 1'b1;
    send_bytes(bad, 3);
    n_tests++; if (err_code_q.size() != 1 || (err_code_q.size() > 0 && err_code_q[0] != 1)) begin
      n_fail++; $display("FAIL csum_err got n=%0d code=%0d exp n=1 code=1", err_code_q.size(),
                         err_code_q.size() > 0 ? err_code_q[0] : -1); end
    n_tests++; if (got_data.size() != 0 || ok_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL csum_leak got bytes=%0d ok=%0d exp 0/0", got_data.size(), ok_cyc_q.size()); end
    send_bytes(good, 3);
    idle(5);
    n_tests++; if (got_data.size() != 3 || ok_cyc_q.size() != 1 || err_code_q.size() != 1) begin
      n_fail++; $display("FAIL csum_recover got bytes=%0d ok=%0d err=%0d exp 3/1/1",
                         got_data.size(), ok_cyc_q.size(), err_code_q.size()); end
  endtask

  task automatic test_len_err();
    logic [7:0] f[$] = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    logic [7:0] m[$];
    logic [7:0] s;
    clear_q();
    out_ready = 1'b1;
    send_bytes(f, 2);
    n_tests++; if (err_code_q.size() != 2 || (err_code_q.size() == 2 && (err_code_q[0] != 0 || err_code_q[1] != 0))) begin
      n_fail++; $display("FAIL len_err got n=%0d exp 2 code-0 pulses", err_code_q.size()); end
    m.push_back(8'hA5); m.push_back(8'(MAX_LEN));
    s = 8'(MAX_LEN);
    for (int k = 0; k < MAX_LEN; k++) begin
      m.push_back(8'(k * 13 + 1));
      s = s + 8'(k * 13 + 1);
    end
    m.push_back(8'h00 - s);
    send_bytes(m, 1);
    idle(MAX_LEN + 4);
    n_tests++; if (got_data.size() != MAX_LEN || ok_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL len_max got bytes=%0d ok=%0d exp %0d/1", got_data.size(), ok_cyc_q.size(), MAX_LEN); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_tests++; if (got_data[k] !== 8'(k * 13 + 1) || got_last[k] !== (k == MAX_LEN - 1)) begin
        n_fail++; $display("FAIL len_max_byte%0d got %0h/%0b exp %0h/%0b", k, got_data[k], got_last[k],
                           8'(k * 13 + 1), (k == MAX_LEN - 1)); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] f[$] = '{8'hA5, 8'h04, 8'h01};
    logic [7:0] g[$] = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    int c0;
    clear_q();
    out_ready = 1'b1;
    send_bytes(f, 1);
    c0 = last_edge;
    idle(TOUT + 5);
    n_tests++; if (err_code_q.size() != 1 || (err_code_q.size() > 0 && err_code_q[0] != 2)) begin
      n_fail++; $display("FAIL tout_code got n=%0d exp one code-2 pulse", err_code_q.size()); end
    n_tests++; if (err_cyc_q.size() > 0 && err_cyc_q[0] != c0 + TOUT + 1) begin
      n_fail++; $display("FAIL tout_cycle got %0d exp %0d", err_cyc_q[0], c0 + TOUT + 1); end
    send_bytes(g, 3);
    idle(4);
    n_tests++; if (got_data.size() != 1 || ok_cyc_q.size() != 1 ||
                   (got_data.size() == 1 && (got_data[0] !== 8'h7F || got_last[0] !== 1'b1))) begin
      n_fail++; $display("FAIL tout_recover got bytes=%0d ok=%0d exp one 7F last", got_data.size(), ok_cyc_q.size()); end
  endtask

  task automatic test_overrun_reset();
    logic [7:0] f[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    clear_q();
    out_ready = 1'b0;
    send_bytes(f, 2);
    drive_byte(8'h55);
    idle(2);
    n_tests++; if (err_code_q.size() != 1 || (err_code_q.size() > 0 && err_code_q[0] != 3)) begin
      n_fail++; $display("FAIL ovr_code got n=%0d exp one code-3 pulse", err_code_q.size()); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL ovr_hold got %0b/%0h/%0b exp 1/11/0", out_valid, out_data, out_last); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h22 || got_data.size() != 1) begin
      n_fail++; $display("FAIL ovr_continue got %0b/%0h n=%0d exp 1/22/1", out_valid, out_data, got_data.size()); end
    rst_n = 1'b0;
    idle(1);
    n_tests++; if ({out_valid, out_data, out_last, frame_ok, frame_err, err_code} !== 13'b0) begin
      n_fail++; $display("FAIL rst_mid got %0h exp 0", {out_valid, out_data, out_last, frame_ok, frame_err, err_code}); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    n_tests++; if (out_valid !== 1'b0 || got_data.size() != 1 || err_code_q.size() != 1 || ok_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL rst_after got valid=%0b bytes=%0d err=%0d ok=%0d exp 0/1/1/1",
                         out_valid, got_data.size(), err_code_q.size(), ok_cyc_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] stream[$];
    logic [7:0] fr[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    int         exp_err[$];
    int         exp_ok;
    int         len, kind, budget, i;
    logic [7:0] s;
    clear_q();
    for (int n = 0; n < 30; n++) begin
      fr.delete();
      kind = $urandom_range(0, 5);
      if (kind <= 2 || kind == 3) begin
        len = $urandom_range(1, MAX_LEN);
        fr.push_back(8'hA5); fr.push_back(8'(len));
        s = 8'(len);
        for (int k = 0; k < len; k++) begin
          fr.push_back(8'($urandom_range(0, 255)));
          s = s + fr[fr.size() - 1];
        end
        fr.push_back((kind == 3) ? 8'($urandom_range(0, 255)) : 8'h00 - s);
      end else if (kind == 4) begin
        fr.push_back(8'hA5);
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        fr.push_back(8'($urandom_range(0, 255)));
        if (fr[0] == 8'hA5) fr[0] = 8'h5A;
      end
      out_ready = 1'b0;
      foreach (fr[k]) begin
        drive_byte(fr[k]);
        stream.push_back(fr[k]);
        idle($urandom_range(0, 3));
      end
      budget = 0;
      while (out_valid && budget < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        idle(1);
        budget++;
      end
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain_timeout frame %0d got valid 1 exp 0", n); end
    end
    exp_ok = 0;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5) begin i++; continue; end
      len = int'(stream[i + 1]);
      if (len == 0 || len > MAX_LEN) begin exp_err.push_back(0); i += 2; continue; end
      s = 8'(len);
      for (int k = 0; k <= len; k++) s = s + stream[i + 2 + k];
      if (s == 8'h00) begin
        exp_ok++;
        for (int k = 0; k < len; k++) begin
          exp_data.push_back(stream[i + 2 + k]);
          exp_last.push_back(k == len - 1);
        end
      end else exp_err.push_back(1);
      i += len + 3;
    end
    n_tests++; if (got_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL rnd_count got %0d exp %0d", got_data.size(), exp_data.size()); end
    for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
      n_tests++; if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
        n_fail++; $display("FAIL rnd_byte%0d got %0h/%0b exp %0h/%0b", k, got_data[k], got_last[k], exp_data[k], exp_last[k]); end
    end
    n_tests++; if (ok_cyc_q.size() != exp_ok) begin n_fail++; $display("FAIL rnd_ok got %0d exp %0d", ok_cyc_q.size(), exp_ok); end
    n_tests++; if (err_code_q.size() != exp_err.size()) begin
      n_fail++; $display("FAIL rnd_err_count got %0d exp %0d", err_code_q.size(), exp_err.size()); end
    for (int k = 0; k < err_code_q.size() && k < exp_err.size(); k++) begin
      n_tests++; if (err_code_q[k] != exp_err[k]) begin
        n_fail++; $display("FAIL rnd_err%0d got %0d exp %0d", k, err_code_q[k], exp_err[k]); end
    end
  endtask

  task automatic test_invariants();
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL invariants got %0d violations exp 0", viol); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_csum();
    test_len_err();
    test_timeout();
    test_overrun_reset();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Framing stage directly downstream of the UART receiver. Consumes the raw byte stream (single-cycle data/valid pulses, no backpressure) and extracts checksummed frames of the form SOF, LEN, payload, CSUM. Payload is held in an internal buffer and released downstream over a valid/ready stream only after the checksum passes, so consumers never see corrupt frames. Errors are reported as pulses with a code.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; informational, used only to derive the default TIMEOUT_CYCLES.
MAX_LEN, 16, maximum payload bytes per frame (1..255); sets the buffer depth.
SOF, 8'hA5, start-of-frame byte.
TIMEOUT_CYCLES, 43400, maximum idle clocks between bytes inside a frame (about 10 byte times at 115200 baud on a 50 MHz clock).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_data  in  8  received byte; sampled only when in_valid=1
in_valid  in  1  single-cycle pulse per received byte; cannot be stalled
out_data  out  8  payload byte
out_valid  out  1  payload byte available
out_ready  in  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1
out_last  out  1  high with the final payload byte of the frame
frame_ok  out  1  1-cycle pulse: frame passed the checksum
frame_err  out  1  1-cycle pulse: error detected
err_code  out  2  valid when frame_err=1: 0 bad LEN, 1 checksum, 2 timeout, 3 overrun

Behaviour:
- Reset: one clock, synchronous and active-low (clk, rst_n). While rst_n=0 on a rising edge, all outputs go to 0 (out_data=8'h00, err_code=2'b00), the state goes to HUNT, and counters, the timer and the checksum clear. A reset in the middle of a frame or drain discards the frame; no pulses are emitted.
- FSM states: HUNT, LEN, PAYLOAD, CSUM, DRAIN.
- HUNT: on in_valid with in_data==SOF, go to LEN. Other bytes are ignored silently. sum<=0.
- LEN:
  - If in_valid and in_data is 0 or greater than MAX_LEN: pulse frame_err with code 0, go to HUNT.
  - Otherwise latch len, set sum<=in_data and idx<=0, go to PAYLOAD.
- PAYLOAD: each in_valid writes buf[idx]<=in_data, sum<=sum+in_data (mod 256), and idx increments. When idx==len-1 is written, go to CSUM.
- CSUM: on in_valid, check (sum+in_data) mod 256.
  - If it is 0: pulse frame_ok on the next cycle, enter DRAIN with rd_idx=0.
  - Otherwise: pulse frame_err with code 1, go to HUNT.
- Timeout: in LEN, PAYLOAD and CSUM, a timer counts clocks since the last in_valid.
  - The timer clears on every in_valid and on entry to LEN.
  - On reaching TIMEOUT_CYCLES: pulse frame_err with code 2, go to HUNT. A byte arriving on that same cycle is dropped.
  - The timer is inactive in HUNT and DRAIN.
- DRAIN:
  - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1).
  - out_data, out_valid and out_last are registered and must stay stable while out_valid=1 and out_ready=0.
  - On a transfer, rd_idx increments. The transfer with out_last=1 returns the FSM to HUNT, and out_valid is 0 on the next cycle.
  - First out_valid appears in the same cycle as frame_ok (one clock after the CSUM byte is sampled).
- Overrun: any in_valid while in DRAIN, including the final-transfer cycle, is dropped. It produces frame_err with code 3; the drain continues unaffected.
- Simultaneous events: timeout has priority over a byte on the same cycle. frame_err and frame_ok never assert in the same cycle.
- Arithmetic and widths:
  - sum is 8 bits and wraps.
  - idx and rd_idx are clog2(MAX_LEN+1) bits.
  - The timer is clog2(TIMEOUT_CYCLES+1) bits and saturates at TIMEOUT_CYCLES.
- Reset and error priority:
  - rst_n=0 overrides everything.
  - frame_err and err_code are registered pulses, so err_code is 0 whenever frame_err is 0.

Test Plan:
- Good frame: bytes A5 03 11 22 33 97, spaced 434 cycles, out_ready=1. Expected: frame_ok once; out 11, 22, 33 on consecutive cycles; out_last only on 33; then back to HUNT.
- Backpressure: same frame with out_ready toggled 0/1 every 3 cycles. Expected: out_data/out_valid/out_last hold while stalled; the sequence is 11, 22, 33 exactly once.
- Bad checksum: A5 02 10 20 00. Expected: frame_err with code 1; no out_valid. Then a garbage byte 5A, then the good frame. Expected: 5A is ignored and the good frame is delivered.
- LEN errors: A5 00 gives frame_err code 0. A5 11 with MAX_LEN=16 gives frame_err code 0. Expected: FSM in HUNT afterwards.
- Timeout: A5 04 01, then idle 43400 cycles. Expected: frame_err code 2 exactly at the timeout. Then a full frame A5 01 7F 80 is accepted normally.
- Overrun and reset: hold out_ready=0 after a good frame, then inject byte 55. Expected: frame_err code 3 and the drain intact. Then rst_n=0 for 1 cycle mid-drain. Expected: all outputs 0 and out_valid low the cycle after.
